// File: rtl/fetch_pkg.sv
// Shared fetch-side constants: NOP encoding, default widths, count sizing.
package fetch_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int PC_W_DEF    = 16;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch buffer.
// One write port and one asynchronous read port.
module fetch_buffer_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so the array is not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// DEPTH-entry instruction/PC FIFO between fetch and decode.
// Define FETCH_BUFFER_BYPASS_EN for a zero-latency path when empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        in_instr,
  input  logic [PC_W-1:0]           in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [PC_W-1:0]           out_pc,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int W  = INSTR_W + PC_W;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty;
  logic          full;
  logic          push;
  logic          byp;
  logic          wr_en;
  logic          rd_en;
  logic [W-1:0]  rdata;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid & in_ready;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign byp = empty & !flush & in_valid;
`else
  assign byp = 1'b0;
`endif

  // A bypassed instruction taken by decode is never stored.
  assign wr_en = push & !flush & !(byp & out_ready);
  assign rd_en = !empty & out_ready & !flush;

  fetch_buffer_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_instr, in_pc}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    out_valid = 1'b0;
    out_instr = NOP_INSTR;
    out_pc    = '0;
    unique case (1'b1)
      !empty: begin
        out_valid = 1'b1;
        out_instr = rdata[W-1:PC_W];
        out_pc    = rdata[PC_W-1:0];
      end
      byp: begin
        out_valid = 1'b1;
        out_instr = in_instr;
        out_pc    = in_pc;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(rd_en);
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Parametrised instruction/PC buffer between the fetch stage and decode. It replaces the single-entry IF/ID register with a DEPTH-entry FIFO.
- Valid/ready handshakes on both sides; synchronous flush for branch/jump redirect.
- When empty, drives a NOP instruction toward decode, so the stage presents a bubble exactly as the old IF/ID buffer did.

Parameters:
- INSTR_W, 16, instruction width in bits.
- PC_W, 16, program-counter width in bits.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous discard of all buffered entries (branch taken / redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept; equals !full.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  PC_W  PC of fetched instruction.
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode consumes head this cycle.
- out_instr  out  INSTR_W  head instruction; NOP_INSTR when !out_valid.
- out_pc  out  PC_W  head PC; 0 when !out_valid.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, rst=1):
  - count=0, read/write pointers=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0.
  - in_ready=1.
  - Storage contents are don't-care.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated on the rising edge of clk.
- Latency (macro off): an entry pushed at edge N is visible on out_* after edge N (1 cycle). FIFO order is strictly preserved.
- Full (count==DEPTH):
  - in_ready=0 and push is ignored, even if pop occurs in the same cycle.
  - There is no pass-through when full.
- Empty (count==0):
  - out_valid=0 and out_ready is ignored.
  - out_instr=NOP_INSTR, out_pc=0.
- Count update on each edge:
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - Push only: count+1.
  - Pop only: count-1.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Flush has priority over push and pop:
  - On an edge with flush=1: count=0, rd_ptr=wr_ptr=0, out_valid=0 from the next cycle.
  - Any push in that cycle is dropped.
  - in_ready is not gated by flush.
- Flush asserted over several cycles: the buffer stays empty for all of them.
- Reset mid-operation: all state clears immediately (asynchronously). There is no partial drain.
- out_instr/out_pc are combinational reads of the head entry, muxed to NOP/0 when empty. They are stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined:
  - When count==0 and flush=0, in_valid passes combinationally: out_valid=in_valid, out_instr=in_instr, out_pc=in_pc.
  - If out_ready=1 in that cycle, the instruction is consumed and not written; count stays 0.
  - If out_ready=0, the instruction is written normally.
  - Result: zero-latency fetch-to-decode when empty.
- Not defined: the strict 1-cycle latency above applies; there is no combinational in-to-out path.

Decomposition:
- Shared package fetch_pkg holds:
  - NOP_INSTR (all zeros, INSTR_W wide).
  - Default INSTR_W/PC_W constants shared with the datapath.
  - A function for the count width.
- Sub-module fetch_buffer_mem:
  - DEPTH x (INSTR_W+PC_W) register array.
  - One write port with write enable; one asynchronous read port.
- Control (pointers, count, flush, bypass) stays in fetch_buffer.

Test Plan:
1. Reset then fill: rst=1 for 2 cycles, release, then push PC 0x0000..0x0003 with instr 0x1111..0x4444 and out_ready=0.
   -> count=4, in_ready=0, out_instr=0x1111, out_pc=0x0000.
2. Drain order: from the full state, out_ready=1 for 4 cycles.
   -> out_instr sequence is 0x1111, 0x2222, 0x3333, 0x4444, then out_valid=0 and out_instr=0x0000.
3. Simultaneous push/pop:
   - At count=2, push 0x5555 with out_ready=1 for 3 cycles -> count stays 2, no loss, wrap-around is exercised.
   - At full, push plus pop -> push is dropped and count=3.
4. Flush: with count=3, assert flush together with in_valid (instr 0x6666) for 1 cycle.
   -> next cycle count=0, out_valid=0, out_instr=0x0000; 0x6666 never appears.
5. Async reset mid-stream: assert rst between clock edges while count=2.
   -> count=0 and out_valid=0 immediately, before the next edge.
6. FETCH_BUFFER_BYPASS_EN, empty, in_valid=1 instr 0x7777, out_ready=1.
   -> out_instr=0x7777 in the same cycle and count stays 0. With the macro off, 0x7777 appears one cycle later.
